// File: rtl/cpu_data_io_pkg.sv
// cpu_data_pkg: address map helpers and encodings shared by the CPU data I/O block
package cpu_data_pkg;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    localparam logic [1:0] ARM_MAX = 2'd3;

    function automatic int port_base(input int reg_size);
        return reg_size;
    endfunction

    function automatic int flag_addr(input int reg_size, input int num_ports);
        return reg_size + 2 * num_ports;
    endfunction

endpackage

// File: rtl/cpu_data_io_if.sv
// cpu_data_io_if: register-file access bus between control unit/ALU and the data I/O block
interface cpu_data_io_if #(
    parameter int WIDTH          = 8,
    parameter int REG_F_SEL_SIZE = 5
);

    logic [REG_F_SEL_SIZE-1:0] REG_F_SEL;
    logic                      EN_REG_F;
    logic [WIDTH-1:0]          IN;
    logic [WIDTH-1:0]          OUT;
    logic                      PORT_IRQ;

    modport master (output REG_F_SEL, EN_REG_F, IN, input OUT, PORT_IRQ);
    modport slave  (input REG_F_SEL, EN_REG_F, IN, output OUT, PORT_IRQ);

endinterface

// File: rtl/cpu_data_io_port_cell.sv
// io_port_cell: one bidirectional port with data latch, direction, pin sync chain and change detect
module io_port_cell
    import cpu_data_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_pd,
    input  logic             wr_dir,
    input  logic             armed,
    input  logic [WIDTH-1:0] wdata,
    inout  wire  [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pd_rd,
    output logic [WIDTH-1:0] dir_rd,
    output logic             chg
);

    logic [WIDTH-1:0] pd_q, pd_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] s3_q, s3_d;
    logic [WIDTH-1:0] hit;
    logic             chg_q, chg_d;

    // s3 follows s2 regardless of direction, so a DIR switch alone never looks like an edge
    always_comb begin
        pd_d  = wr_pd ? wdata : pd_q;
        dir_d = wr_dir ? wdata : dir_q;
        s1_d  = pin;
        s2_d  = s1_q;
        s3_d  = s2_q;
        hit   = ~dir_q & (s2_q ^ s3_q);
        pd_rd = (dir_q & pd_q) | (~dir_q & s2_q);
        chg_d = armed && (|hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd_q  <= '0;
            dir_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            chg_q <= 1'b0;
        end else begin
            pd_q  <= pd_d;
            dir_q <= dir_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            chg_q <= chg_d;
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign pin[b] = (dir_q[b] == DIR_OUT) ? pd_q[b] : 1'bz;
    end

    assign dir_rd = dir_q;
    assign chg    = chg_q;

endmodule

// File: rtl/cpu_data_io.sv
// cpu_data_io: general register file plus memory-mapped bidirectional ports with change IRQ
module cpu_data_io
    import cpu_data_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int REG_SIZE       = 9,
    parameter int NUM_PORTS      = 2,
    parameter int REG_F_SEL_SIZE = 5
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    cpu_data_io_if.slave                 bus,
    inout  wire  [NUM_PORTS*WIDTH-1:0]   PORT
);

    localparam int PORT_B = port_base(REG_SIZE);
    localparam int FLAG_A = flag_addr(REG_SIZE, NUM_PORTS);

    logic [WIDTH-1:0]     gr_q [REG_SIZE];
    logic [WIDTH-1:0]     gr_d [REG_SIZE];
    logic [NUM_PORTS-1:0] flag_q, flag_d;
    logic [1:0]           arm_q, arm_d;
    logic [NUM_PORTS-1:0] chg, wr_pd, wr_dir;
    logic [WIDTH-1:0]     pd_rd  [NUM_PORTS];
    logic [WIDTH-1:0]     dir_rd [NUM_PORTS];
    logic [WIDTH-1:0]     rd;
    logic [31:0]          sel;
    logic                 armed, wr_flag;

    // set is ORed in after the W1C mask so a same-edge event is never lost
    always_comb begin
        sel     = 32'(bus.REG_F_SEL);
        armed   = arm_q == ARM_MAX;
        arm_d   = armed ? arm_q : arm_q + 2'd1;
        wr_flag = bus.EN_REG_F && sel == FLAG_A;
        flag_d  = (flag_q & ~(wr_flag ? bus.IN[NUM_PORTS-1:0] : '0)) | chg;
        rd      = (sel == FLAG_A) ? WIDTH'(flag_q) : '0;
        gr_d    = gr_q;
        wr_pd   = '0;
        wr_dir  = '0;
        for (int i = 0; i < REG_SIZE; i++) begin
            gr_d[i] = (bus.EN_REG_F && sel == i) ? bus.IN : gr_q[i];
            rd      = (sel == i) ? gr_q[i] : rd;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_pd[p]  = bus.EN_REG_F && sel == PORT_B + 2 * p;
            wr_dir[p] = bus.EN_REG_F && sel == PORT_B + 2 * p + 1;
            rd = (sel == PORT_B + 2 * p)     ? pd_rd[p]  :
                 (sel == PORT_B + 2 * p + 1) ? dir_rd[p] : rd;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gr_q   <= '{default: '0};
            flag_q <= '0;
            arm_q  <= '0;
        end else begin
            gr_q   <= gr_d;
            flag_q <= flag_d;
            arm_q  <= arm_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        io_port_cell #(.WIDTH(WIDTH)) u_cell (
            .clk    (CLK),
            .rst_n  (RST_N),
            .wr_pd  (wr_pd[p]),
            .wr_dir (wr_dir[p]),
            .armed  (armed),
            .wdata  (bus.IN),
            .pin    (PORT[p*WIDTH +: WIDTH]),
            .pd_rd  (pd_rd[p]),
            .dir_rd (dir_rd[p]),
            .chg    (chg[p])
        );
    end

    assign bus.OUT      = rd;
    assign bus.PORT_IRQ = |flag_q;

endmodule

// File: doc/cpu_data_io.md
Name: cpu_data_io

Overview:
- Parametrised successor to the CPU data block. It holds a general register file plus NUM_PORTS memory-mapped bidirectional I/O ports.
- Each port has a per-bit direction register, a 2-flop input synchroniser and a sticky change-detect flag.
- Sits between the single-cycle control unit (supplies REG_F_SEL/EN_REG_F) and the ALU/accumulator (drives IN, consumes OUT).

Parameters:
- WIDTH, 8, data width of every register and port.
- REG_SIZE, 9, number of general-purpose registers.
- NUM_PORTS, 2, number of bidirectional ports; must satisfy 1 <= NUM_PORTS <= WIDTH.
- REG_F_SEL_SIZE, 5, select width; must satisfy 2^REG_F_SEL_SIZE >= REG_SIZE + 2*NUM_PORTS + 1.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  asynchronous, active-low reset.
- REG_F_SEL  input  REG_F_SEL_SIZE  register/port address.
- EN_REG_F  input  1  write enable for the addressed location.
- IN  input  WIDTH  write data.
- OUT  output  WIDTH  combinational read data of the addressed location.
- PORT  inout  NUM_PORTS*WIDTH  external pins; port p occupies bits [p*WIDTH +: WIDTH].
- PORT_IRQ  output  1  OR of all change flags.

Behaviour:
- Address map:
  - 0..REG_SIZE-1: general registers GR[i].
  - REG_SIZE+2p: port p data (PD).
  - REG_SIZE+2p+1: port p direction (DIR); bit = 1 means output.
  - REG_SIZE+2*NUM_PORTS: FLAG register; bit p = port p change flag, upper bits read 0.
  - All higher addresses: read 0, writes ignored.
- Reset (RST_N low, asynchronous): GR, PD latch, DIR, sync flops, FLAG and arm counter all clear to 0. PORT is fully Z. OUT follows SEL combinationally (reads 0 everywhere). PORT_IRQ is 0.
- Writes take effect on the rising CLK edge when EN_REG_F=1. One-cycle latency: a write at edge N is visible on OUT and PORT after edge N.
  - GR and PD writes load the full word.
  - DIR write loads the full word.
  - FLAG write is write-1-to-clear per bit.
- Pin drive: PORT bit b of port p = PD[p][b] when DIR[p][b]=1, else Z.
- Input path: per port, stage1 <= PORT, stage2 <= stage1, stage3 <= stage2 every cycle, regardless of DIR.
- Reading PD[p]: bit b = DIR[p][b] ? PD latch[p][b] : stage2[p][b]. Input bits therefore appear on OUT 2 edges after the pin changes.
- Change detect: flag p sets when any bit b has DIR[p][b]=0 and stage2[b] != stage3[b], and detection is armed.
  - Output bits never set the flag.
  - Flag stays set until cleared via W1C.
- Arm counter: 2-bit saturating counter, 0 after reset, increments each cycle to 3. Detection is armed only when the counter = 3. This masks spurious flags while the sync chain fills after reset.
- Simultaneous flag set and W1C clear on the same edge: set wins, flag stays 1.
- Writing DIR to switch a bit from output to input does not by itself set the flag. Stage3 keeps tracking stage2 throughout, so only a pin transition after the switch counts.
- Reset asserted mid-operation: immediate clear of all state; PORT goes Z without waiting for CLK.
- PORT_IRQ is registered-free: the OR of FLAG bits.

Decomposition:
- Shared package cpu_data_pkg holds:
  - address-offset functions/constants: PORT_BASE = REG_SIZE, FLAG_ADDR = REG_SIZE + 2*NUM_PORTS.
  - DIR encoding constants: DIR_IN = 0, DIR_OUT = 1.
- One sub-module, io_port_cell, instantiated NUM_PORTS times. It contains the PD latch, DIR register, tri-state drivers, sync chain, read mux and change-detect pulse.
- The top level contains the GR array, address decode, FLAG register, arm counter and OUT mux.

Test Plan:
1. Reset with SEL=0; release, write GR[3]=0xA5; read GR[3] -> OUT=0xA5 one cycle after write; address 31 reads 0x00; writes to 31 have no effect.
2. Write DIR0=0xF0, PD0=0x3C -> PORT[7:4] driven 0x3; PORT[3:0] Z; reading PD0 with pins[3:0] driven 0x9 externally -> OUT=0x39, valid 2 edges after the pin change.
3. Hold port 1 pins at 0xFF through reset release -> FLAG stays 0x00 and PORT_IRQ=0 (arm masking); then toggle pin bit 0 to 0 -> FLAG=0x02 on the 4th edge after the pin change (2 sync + 1 compare + 1 flag register), PORT_IRQ=1.
4. With port 0 DIR=0xFF, change PD0 0x00->0xFF -> FLAG bit 0 stays 0.
5. Write FLAG=0x02 on the same edge a new port-1 input change is detected -> FLAG bit 1 remains 1. Write FLAG=0x02 with no event -> FLAG=0x00, PORT_IRQ=0.
6. Assert RST_N low between clock edges while PORT0 is driving 0x3C -> PORT immediately Z, OUT=0 for all addresses, FLAG=0.
